// File: rtl/mem_wb_stage_pkg.sv
// Shared load-type encoding and W-stage bundle for the MEM->WB stage.
// The load-type values are also used by the decoder and dmem byte enables.
package mem_wb_stage_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_LB   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LH   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LW   = 3'd5
    } loadtype_e;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              misalign;
        logic [4:0]        writereg;
        logic [WORD_W-1:0] result;
    } wb_t;

    function automatic logic [WORD_W-1:0] ext8(
        input logic [7:0] b,
        input logic       sgn
    );
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [WORD_W-1:0] ext16(
        input logic [15:0] h,
        input logic        sgn
    );
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load lane extraction and sign/zero extension for a word-addressed dmem.
// Flags halfword/word loads whose address is not naturally aligned.
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]        loadtype,
    input  logic [1:0]        addr,
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] data,
    output logic              misaligned
);

    loadtype_e   lt;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lt = loadtype_e'(loadtype);

    always_comb begin
        lane_b = word[7:0];
        unique case (addr)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
    end

    assign lane_h = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (lt)
            LT_LB:  data = ext8(lane_b, 1'b1);
            LT_LBU: data = ext8(lane_b, 1'b0);
            LT_LH: begin
                data       = ext16(lane_h, 1'b1);
                misaligned = addr[0];
            end
            LT_LHU: begin
                data       = ext16(lane_h, 1'b0);
                misaligned = addr[0];
            end
            LT_LW:  misaligned = |addr;
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: load alignment, write gating,
// stall/flush control and a retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_W,
    input  logic              flush_W,
    input  logic              valid_M,
    input  logic              regwrite_M,
    input  logic              memtoreg_M,
    input  logic [2:0]        loadtype_M,
    input  logic [4:0]        writereg_M,
    input  logic [DATA_W-1:0] aluout_M,
    input  logic [DATA_W-1:0] readdata_M,
    output logic              valid_W,
    output logic              regwrite_W,
    output logic [4:0]        writereg_W,
    output logic [DATA_W-1:0] result_W,
    output logic              misalign_W,
    output logic [CNT_W-1:0]  retired_cnt
);

    logic [WORD_W-1:0] la_data;
    logic              la_mis;
    logic              mis;
    wb_t               w_d;
    wb_t               w_q;
    logic [CNT_W-1:0]  cnt_q;

    load_align u_load_align (
        .loadtype   (loadtype_M),
        .addr       (aluout_M[1:0]),
        .word       (readdata_M),
        .data       (la_data),
        .misaligned (la_mis)
    );

    assign mis = valid_M & memtoreg_M & la_mis;

    // An invalid MEM slot becomes an all-zero bubble.
    always_comb begin
        w_d          = '0;
        w_d.valid    = valid_M;
        w_d.misalign = mis;
        w_d.regwrite = valid_M & regwrite_M & ~mis
                     & (|writereg_M);
        if (valid_M) begin
            w_d.writereg = writereg_M;
            if (!mis)
                w_d.result = memtoreg_M ? la_data
                                        : aluout_M;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q   <= '0;
            cnt_q <= '0;
        end else if (flush_W) begin
            w_q   <= '0;
        end else if (!stall_W) begin
            w_q <= w_d;
            if (valid_M)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign valid_W     = w_q.valid;
    assign regwrite_W  = w_q.regwrite;
    assign writereg_W  = w_q.writereg;
    assign result_W    = w_q.result;
    assign misalign_W  = w_q.misalign;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (counter width 4).
// Each task drives one scenario and checks outputs 1 time unit after the edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_W = 1'b0;
    logic        flush_W = 1'b0;
    logic        valid_M = 1'b0;
    logic        regwrite_M = 1'b0;
    logic        memtoreg_M = 1'b0;
    logic [2:0]  loadtype_M = 3'd0;
    logic [4:0]  writereg_M = 5'd0;
    logic [31:0] aluout_M = 32'd0;
    logic [31:0] readdata_M = 32'd0;
    logic        valid_W;
    logic        regwrite_W;
    logic [4:0]  writereg_W;
    logic [31:0] result_W;
    logic        misalign_W;
    logic [3:0]  retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_stage #(.DATA_W(32), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_W     (stall_W),
        .flush_W     (flush_W),
        .valid_M     (valid_M),
        .regwrite_M  (regwrite_M),
        .memtoreg_M  (memtoreg_M),
        .loadtype_M  (loadtype_M),
        .writereg_M  (writereg_M),
        .aluout_M    (aluout_M),
        .readdata_M  (readdata_M),
        .valid_W     (valid_W),
        .regwrite_W  (regwrite_W),
        .writereg_W  (writereg_W),
        .result_W    (result_W),
        .misalign_W  (misalign_W),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(
        input logic        v,
        input logic        rw,
        input logic        mtr,
        input logic [2:0]  lt,
        input logic [4:0]  wr,
        input logic [31:0] alu,
        input logic [31:0] rd
    );
        valid_M    = v;
        regwrite_M = rw;
        memtoreg_M = mtr;
        loadtype_M = lt;
        writereg_M = wr;
        aluout_M   = alu;
        readdata_M = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_checks++;
        if ({valid_W, regwrite_W, misalign_W, writereg_W} !== 8'd0
            || result_W !== 32'd0 || retired_cnt !== 4'd0) begin
            $display("FAIL reset_init got v%b rw%b m%b wr%0d r%h c%0d exp all 0",
                     valid_W, regwrite_W, misalign_W, writereg_W,
                     result_W, retired_cnt);
            n_fail++;
        end
        reset = 1'b0;
        drive(1, 1, 0, 3'd0, 5'd3, 32'h55, 32'h0);
        step();
        step();
        n_checks++;
        if (retired_cnt !== 4'd2 || result_W !== 32'h55) begin
            $display("FAIL pre_reset_traffic got c%0d r%h exp c2 r00000055",
                     retired_cnt, result_W);
            n_fail++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({valid_W, regwrite_W, misalign_W, writereg_W} !== 8'd0
            || result_W !== 32'd0 || retired_cnt !== 4'd0) begin
            $display("FAIL reset_mid got v%b rw%b m%b wr%0d r%h c%0d exp all 0",
                     valid_W, regwrite_W, misalign_W, writereg_W,
                     result_W, retired_cnt);
            n_fail++;
        end
    endtask

    task automatic test_byte_loads();
        drive(1, 1, 1, 3'd1, 5'd5, 32'h0000_1003, 32'h80FF_1234);
        step();
        n_checks++;
        if (result_W !== 32'hFFFF_FF80 || regwrite_W !== 1'b1
            || writereg_W !== 5'd5 || valid_W !== 1'b1) begin
            $display("FAIL lb got r%h rw%b wr%0d exp rFFFFFF80 rw1 wr5",
                     result_W, regwrite_W, writereg_W);
            n_fail++;
        end
        drive(1, 1, 1, 3'd2, 5'd6, 32'h0000_1003, 32'h80FF_1234);
        step();
        n_checks++;
        if (result_W !== 32'h0000_0080 || regwrite_W !== 1'b1) begin
            $display("FAIL lbu got r%h rw%b exp r00000080 rw1",
                     result_W, regwrite_W);
            n_fail++;
        end
        drive(1, 1, 1, 3'd1, 5'd6, 32'h0000_1001, 32'h80FF_1234);
        step();
        n_checks++;
        if (result_W !== 32'h0000_0012) begin
            $display("FAIL lb_lane1 got r%h exp r00000012", result_W);
            n_fail++;
        end
    endtask

    task automatic test_half_word_loads();
        drive(1, 1, 1, 3'd3, 5'd7, 32'h0000_2002, 32'h8001_7FFF);
        step();
        n_checks++;
        if (result_W !== 32'hFFFF_8001 || misalign_W !== 1'b0
            || regwrite_W !== 1'b1) begin
            $display("FAIL lh got r%h m%b rw%b exp rFFFF8001 m0 rw1",
                     result_W, misalign_W, regwrite_W);
            n_fail++;
        end
        drive(1, 1, 1, 3'd4, 5'd7, 32'h0000_2000, 32'h8001_7FFF);
        step();
        n_checks++;
        if (result_W !== 32'h0000_7FFF) begin
            $display("FAIL lhu got r%h exp r00007FFF", result_W);
            n_fail++;
        end
        drive(1, 1, 1, 3'd3, 5'd7, 32'h0000_2001, 32'h8001_7FFF);
        step();
        n_checks++;
        if (misalign_W !== 1'b1 || regwrite_W !== 1'b0
            || result_W !== 32'd0 || valid_W !== 1'b1) begin
            $display("FAIL lh_misalign got m%b rw%b r%h v%b exp m1 rw0 r0 v1",
                     misalign_W, regwrite_W, result_W, valid_W);
            n_fail++;
        end
        drive(1, 1, 1, 3'd5, 5'd9, 32'h0000_2002, 32'hDEAD_BEEF);
        step();
        n_checks++;
        if (misalign_W !== 1'b1 || regwrite_W !== 1'b0
            || result_W !== 32'd0) begin
            $display("FAIL lw_misalign got m%b rw%b r%h exp m1 rw0 r0",
                     misalign_W, regwrite_W, result_W);
            n_fail++;
        end
        drive(1, 1, 1, 3'd5, 5'd9, 32'h0000_2004, 32'hDEAD_BEEF);
        step();
        n_checks++;
        if (result_W !== 32'hDEAD_BEEF || misalign_W !== 1'b0
            || regwrite_W !== 1'b1) begin
            $display("FAIL lw got r%h m%b rw%b exp rDEADBEEF m0 rw1",
                     result_W, misalign_W, regwrite_W);
            n_fail++;
        end
        drive(1, 1, 1, 3'd0, 5'd9, 32'h0000_2003, 32'hCAFE_F00D);
        step();
        n_checks++;
        if (result_W !== 32'hCAFE_F00D || misalign_W !== 1'b0) begin
            $display("FAIL lt_none got r%h m%b exp rCAFEF00D m0",
                     result_W, misalign_W);
            n_fail++;
        end
    endtask

    task automatic test_alu_writes();
        drive(1, 1, 0, 3'd5, 5'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        step();
        n_checks++;
        if (regwrite_W !== 1'b0 || result_W !== 32'h1234
            || misalign_W !== 1'b0) begin
            $display("FAIL alu_r0 got rw%b r%h m%b exp rw0 r00001234 m0",
                     regwrite_W, result_W, misalign_W);
            n_fail++;
        end
        drive(1, 1, 0, 3'd0, 5'd8, 32'h0000_1234, 32'h0);
        step();
        n_checks++;
        if (regwrite_W !== 1'b1 || result_W !== 32'h1234
            || writereg_W !== 5'd8) begin
            $display("FAIL alu_r8 got rw%b r%h wr%0d exp rw1 r00001234 wr8",
                     regwrite_W, result_W, writereg_W);
            n_fail++;
        end
        drive(1, 0, 0, 3'd0, 5'd8, 32'h0000_4321, 32'h0);
        step();
        n_checks++;
        if (regwrite_W !== 1'b0 || valid_W !== 1'b1) begin
            $display("FAIL no_regwrite got rw%b v%b exp rw0 v1",
                     regwrite_W, valid_W);
            n_fail++;
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1, 1, 0, 3'd0, 5'd9, 32'h0000_AAAA, 32'h0);
        step();
        stall_W = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 3'd1, 5'(10 + i), 32'(i), 32'h1111_1111 * i);
            step();
            n_checks++;
            if (result_W !== 32'hAAAA || writereg_W !== 5'd9
                || regwrite_W !== 1'b1 || retired_cnt !== 4'd1) begin
                $display("FAIL stall_hold%0d got r%h wr%0d rw%b c%0d exp r0000AAAA wr9 rw1 c1",
                         i, result_W, writereg_W, regwrite_W, retired_cnt);
                n_fail++;
            end
        end
        flush_W = 1'b1;
        step();
        n_checks++;
        if (valid_W !== 1'b0 || regwrite_W !== 1'b0 || writereg_W !== 5'd0
            || result_W !== 32'd0 || retired_cnt !== 4'd1) begin
            $display("FAIL stall_flush got v%b rw%b wr%0d r%h c%0d exp bubble c1",
                     valid_W, regwrite_W, writereg_W, result_W, retired_cnt);
            n_fail++;
        end
        stall_W = 1'b0;
        drive(1, 1, 0, 3'd0, 5'd4, 32'h77, 32'h0);
        step();
        n_checks++;
        if (valid_W !== 1'b0 || result_W !== 32'd0 || retired_cnt !== 4'd1) begin
            $display("FAIL flush got v%b r%h c%0d exp v0 r0 c1",
                     valid_W, result_W, retired_cnt);
            n_fail++;
        end
        flush_W = 1'b0;
        drive(0, 1, 0, 3'd0, 5'd4, 32'h77, 32'h0);
        step();
        n_checks++;
        if (valid_W !== 1'b0 || regwrite_W !== 1'b0 || writereg_W !== 5'd0
            || result_W !== 32'd0 || retired_cnt !== 4'd1) begin
            $display("FAIL invalid_bubble got v%b rw%b wr%0d r%h c%0d exp bubble c1",
                     valid_W, regwrite_W, writereg_W, result_W, retired_cnt);
            n_fail++;
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            drive(1, 1, 0, 3'd0, 5'd1, 32'(i), 32'h0);
            step();
            if (i == 5) begin
                flush_W = 1'b1;
                step();
                flush_W = 1'b0;
                drive(0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);
                step();
                n_checks++;
                if (retired_cnt !== 4'd5) begin
                    $display("FAIL cnt_skip got c%0d exp c5", retired_cnt);
                    n_fail++;
                end
            end
            if (i == 15 || i == 16) begin
                n_checks++;
                if (retired_cnt !== 4'(i)) begin
                    $display("FAIL cnt_at%0d got c%0d exp c%0d",
                             i, retired_cnt, i % 16);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (retired_cnt !== 4'd1) begin
            $display("FAIL cnt_wrap got c%0d exp c1", retired_cnt);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_byte_loads();
        test_half_word_loads();
        test_alu_writes();
        test_stall_flush();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
